top_level_wrapper: RTL and testbench

TOP_LEVEL_WRAPPER -- requirements
Module: top_level_wrapper

---
 rtl/top_level_wrapper.sv | 168 ++++++++++++++++
 tb/tb_top_level_wrapper.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/top_level_wrapper.sv
// rtl/top_level_wrapper.sv - memory-mapped single-block SHA-1 engine
module top_level_wrapper (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} state_t;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hEFCDAB89;
    localparam logic [31:0] IV2 = 32'h98BADCFE;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hC3D2E1F0;

    state_t      state;
    logic        busy;
    logic        done;
    logic [6:0]  round_cnt;
    logic [31:0] msg   [16];
    logic [31:0] sched [16];
    logic [31:0] h     [5];
    logic [31:0] a, b, c, d, e;

    logic        mapped;
    logic [4:0]  word;
    logic        msg_hit;
    logic        dig_hit;
    logic [3:0]  msg_idx;
    logic [2:0]  dig_idx;
    logic        start_req;
    logic [31:0] rd_mux;
    logic [31:0] f_val;
    logic [31:0] k_val;
    logic [31:0] temp;
    logic [31:0] w_mix;
    logic [31:0] w_next;

    assign mapped    = (address[31:5] == 27'd0);
    assign word      = address[4:0];
    assign msg_hit   = mapped && (word >= 5'd1) && (word <= 5'd16);
    assign dig_hit   = mapped && (word >= 5'd17) && (word <= 5'd21);
    // Word 16 wraps to index 15 through the 4-bit subtraction.
    assign msg_idx   = word[3:0] - 4'd1;
    assign dig_idx   = word[2:0] - 3'd1;
    assign start_req = write && mapped && (word == 5'd0) && writedata[0];

    always_comb begin
        rd_mux = 32'd0;
        if (mapped && word == 5'd0) begin
            rd_mux = {30'd0, done, busy};
        end else if (msg_hit) begin
            rd_mux = msg[msg_idx];
        end else if (dig_hit) begin
            rd_mux = h[dig_idx];
        end
    end

    always_comb begin
        f_val = 32'd0;
        k_val = 32'd0;
        if (round_cnt < 7'd20) begin
            f_val = (b & c) | (~b & d);
            k_val = 32'h5A827999;
        end else if (round_cnt < 7'd40) begin
            f_val = b ^ c ^ d;
            k_val = 32'h6ED9EBA1;
        end else if (round_cnt < 7'd60) begin
            f_val = (b & c) | (b & d) | (c & d);
            k_val = 32'h8F1BBCDC;
        end else begin
            f_val = b ^ c ^ d;
            k_val = 32'hCA62C1D6;
        end
    end

    // sched[0] is W_t; the buffer shifts down one word per round.
    assign temp   = {a[26:0], a[31:27]} + f_val + e + k_val + sched[0];
    assign w_mix  = sched[13] ^ sched[8] ^ sched[2] ^ sched[0];
    assign w_next = {w_mix[30:0], w_mix[31]};

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            readdata  <= 32'd0;
            round_cnt <= 7'd0;
            a <= 32'd0;
            b <= 32'd0;
            c <= 32'd0;
            d <= 32'd0;
            e <= 32'd0;
            for (int i = 0; i < 16; i++) begin
                msg[i]   <= 32'd0;
                sched[i] <= 32'd0;
            end
            for (int i = 0; i < 5; i++) begin
                h[i] <= 32'd0;
            end
        end else begin
            if (read) begin
                readdata <= rd_mux;
            end
            if (write && !busy && msg_hit) begin
                msg[msg_idx] <= writedata;
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    h[0] <= IV0;
                    h[1] <= IV1;
                    h[2] <= IV2;
                    h[3] <= IV3;
                    h[4] <= IV4;
                    a <= IV0;
                    b <= IV1;
                    c <= IV2;
                    d <= IV3;
                    e <= IV4;
                    for (int i = 0; i < 16; i++) begin
                        sched[i] <= msg[i];
                    end
                    round_cnt <= 7'd0;
                    state     <= ROUND;
                end
                ROUND: begin
                    a <= temp;
                    b <= a;
                    c <= {b[1:0], b[31:2]};
                    d <= c;
                    e <= d;
                    for (int i = 0; i < 15; i++) begin
                        sched[i] <= sched[i + 1];
                    end
                    sched[15] <= w_next;
                    round_cnt <= round_cnt + 7'd1;
                    if (round_cnt == 7'd79) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    h[0] <= h[0] + a;
                    h[1] <= h[1] + b;
                    h[2] <= h[2] + c;
                    h[3] <= h[3] + d;
                    h[4] <= h[4] + e;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level_wrapper.sv
// tb/tb_top_level_wrapper.sv - scoreboard bench for the SHA-1 register block
module tb_top_level_wrapper;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] adr_q[$];
    logic issued = 1'b0;

    top_level_wrapper dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .write     (write),
        .read      (read),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) issued <= read & ~reset_n;

    always @(negedge clk) begin
        logic [31:0] ev;
        logic [31:0] ea;
        if (issued) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read got=%h", readdata);
            end else begin
                ev = exp_q.pop_front();
                ea = adr_q.pop_front();
                if (readdata !== ev) begin
                    n_bad++;
                    $display("FAIL read addr=%0d got=%h exp=%h", ea, readdata, ev);
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] dv);
        write = 1'b1; address = a; writedata = dv;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ev);
        read = 1'b1; address = a;
        exp_q.push_back(ev);
        adr_q.push_back(a);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] dv, input logic [31:0] ev);
        write = 1'b1; read = 1'b1; address = a; writedata = dv;
        exp_q.push_back(ev);
        adr_q.push_back(a);
        @(negedge clk);
        write = 1'b0; read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    task automatic load_abc();
        wr(1, 32'h61626380);
        for (int i = 2; i <= 15; i++) wr(i, 32'd0);
        wr(16, 32'h00000018);
    endtask

    task automatic chk_digest(input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] d4);
        rd(17, d0); rd(18, d1); rd(19, d2); rd(20, d3); rd(21, d4);
    endtask

    task automatic chk_abc();
        chk_digest(32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d);
    endtask

    initial begin
        idle(3);
        reset_n = 1'b0;

        for (int i = 0; i <= 21; i++) rd(i, 32'd0);

        // Exact latency: busy on the read sampled 82 edges after start, done on the 83rd.
        load_abc();
        wr(0, 1);
        rd(0, 32'd1);
        idle(80);
        rd(0, 32'd1);
        rd(0, 32'd2);
        chk_abc();
        rd(1, 32'h61626380);
        for (int i = 2; i <= 15; i++) rd(i, 32'd0);
        rd(16, 32'h00000018);

        rw(2, 32'h12345678, 32'd0);
        rd(2, 32'h12345678);
        wr(2, 32'd0);
        wr(22, 32'hdeadbeef);
        rd(22, 32'd0);
        rd(32'h80000001, 32'd0);

        wr(0, 1);
        rd(0, 32'd1);
        idle(85);
        rd(0, 32'd2);
        chk_abc();

        wr(0, 1);
        wr(1, 32'hFFFFFFFF);
        wr(0, 1);
        idle(90);
        rd(0, 32'd2);
        chk_abc();
        rd(1, 32'h61626380);

        wr(1, 32'h80000000);
        wr(16, 32'd0);
        wr(0, 1);
        idle(90);
        rd(0, 32'd2);
        chk_digest(32'hda39a3ee, 32'h5e6b4b0d, 32'h3255bfef, 32'h95601890, 32'hafd80709);

        load_abc();
        wr(0, 1);
        idle(20);
        pulse_reset();
        rd(0, 32'd0);
        chk_digest(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        rd(1, 32'd0);
        idle(90);
        rd(0, 32'd0);
        load_abc();
        wr(0, 1);
        idle(90);
        rd(0, 32'd2);
        chk_abc();

        idle(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_reads got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
